// File: rtl/simple_ctrl_pkg.sv
// Shared state encoding and one-hot phase constants for the SIMPLE datapath sequencer.
package simple_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED
  } state_t;

  localparam logic [4:0] PH_NONE = 5'b00000;
  localparam logic [4:0] PH_P1   = 5'b00001;
  localparam logic [4:0] PH_P2   = 5'b00010;
  localparam logic [4:0] PH_P3   = 5'b00100;
  localparam logic [4:0] PH_P4   = 5'b01000;
  localparam logic [4:0] PH_P5   = 5'b10000;

endpackage

// File: rtl/phase_ring.sv
// Five-bit one-hot phase rotator; clear beats load_p1, which beats advance.
module phase_ring
  import simple_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load_p1,
  input  logic       advance,
  input  logic       clear,
  output logic [4:0] phase,
  output logic       at_p5
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      phase <= PH_NONE;
    else if (clear)
      phase <= PH_NONE;
    else if (load_p1)
      phase <= PH_P1;
    else if (advance)
      phase <= {phase[3:0], phase[4]};
  end

  assign at_p5 = (phase == PH_P5);

endmodule

// File: rtl/phase_controller.sv
// Run/step/halt sequencer with register-file write arbitration.
// Define INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
module phase_controller
  import simple_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               haltin,
  input  logic               wb_req,
  input  logic [RADDR_W-1:0] wb_target,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               dbg_req,
  input  logic [RADDR_W-1:0] dbg_target,
  input  logic [DATA_W-1:0]  dbg_data,
  output logic [4:0]         phase,
  output logic               running,
  output logic               halted,
  output logic               dbg_ack,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [CNT_W-1:0]   instr_count
);

  state_t state, state_nx;
  logic   halt_pending;
  logic   running_nx, halted_nx;
  logic   at_p5, active, retire, halt_now, accept_start;
  logic   ring_clear, wb_go, dbg_go;

  assign active       = (state == ST_RUN) || (state == ST_STEP);
  assign retire       = active && at_p5;
  assign halt_now     = halt_pending || haltin;
  assign accept_start = (state == ST_IDLE) && (run || step);
  assign ring_clear   = retire && (halt_now || (state == ST_STEP));

  phase_ring u_ring (
    .clock   (clock),
    .reset   (reset),
    .load_p1 (accept_start),
    .advance (active),
    .clear   (ring_clear),
    .phase   (phase),
    .at_p5   (at_p5)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= running_nx;
      halted  <= halted_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (run)
          state_nx = ST_RUN;
        else if (step)
          state_nx = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        if (retire) begin
          if (halt_now)
            state_nx = ST_HALTED;
          else if (state == ST_STEP)
            state_nx = ST_IDLE;
        end
      end
      default: state_nx = state;
    endcase
  end

  // running/halted are decoded from the next state so they are flops aligned with phase.
  always_comb begin
    running_nx = (state_nx == ST_RUN) || (state_nx == ST_STEP);
    halted_nx  = (state_nx == ST_HALTED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      halt_pending <= 1'b0;
    else if (retire)
      halt_pending <= 1'b0;
    else if (active && haltin)
      halt_pending <= 1'b1;
  end

  // Writeback only occurs while executing and debug only while stopped, so they never collide.
  assign wb_go  = retire && wb_req;
  assign dbg_go = ((state == ST_IDLE) || (state == ST_HALTED)) && dbg_req && !dbg_ack
                  && !accept_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      dbg_ack  <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we   <= wb_go || dbg_go;
      dbg_ack <= dbg_go;
      if (wb_go) begin
        rf_waddr <= wb_target;
        rf_wdata <= wb_data;
      end else if (dbg_go) begin
        rf_waddr <= dbg_target;
        rf_wdata <= dbg_data;
      end
    end
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      instr_count <= '0;
    else if (retire)
      instr_count <= instr_count + CNT_W'(1);
  end
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_phase_controller.sv
// Scoreboard bench for phase_controller: a behavioural model predicts every cycle's outputs.
module tb_phase_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0, step = 1'b0, haltin = 1'b0;
  logic        wb_req = 1'b0, dbg_req = 1'b0;
  logic [2:0]  wb_target = '0, dbg_target = '0;
  logic [15:0] wb_data = '0, dbg_data = '0;
  logic [4:0]  phase;
  logic        running, halted, dbg_ack, rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  phase_controller #(.DATA_W(16), .RADDR_W(3), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .haltin      (haltin),
    .wb_req      (wb_req),
    .wb_target   (wb_target),
    .wb_data     (wb_data),
    .dbg_req     (dbg_req),
    .dbg_target  (dbg_target),
    .dbg_data    (dbg_data),
    .phase       (phase),
    .running     (running),
    .halted      (halted),
    .dbg_ack     (dbg_ack),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .instr_count (instr_count)
  );

  typedef struct {
    logic [4:0]  phase;
    logic        running;
    logic        halted;
    logic        ack;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  // model: m_st 0=idle 1=run 2=step 3=halted; m_ph 0=none, 1..5 phase number
  int          m_st = 0, m_ph = 0;
  logic        m_hp = 1'b0, m_we = 1'b0, m_ack = 1'b0;
  logic [2:0]  m_wa = '0;
  logic [15:0] m_wd = '0, m_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_hp = 1'b0; m_we = 1'b0; m_ack = 1'b0;
    m_wa = '0; m_wd = '0; m_cnt = '0;
  endtask

  task automatic model_step();
    logic we, ack, hp;
    we = 1'b0; ack = 1'b0;
    if (m_st == 0) begin
      if (run) begin m_st = 1; m_ph = 1; end
      else if (step) begin m_st = 2; m_ph = 1; end
      else if (dbg_req && !m_ack) begin
        we = 1'b1; ack = 1'b1; m_wa = dbg_target; m_wd = dbg_data;
      end
    end else if (m_st == 3) begin
      if (dbg_req && !m_ack) begin
        we = 1'b1; ack = 1'b1; m_wa = dbg_target; m_wd = dbg_data;
      end
    end else begin
      hp = m_hp || haltin;
      if (m_ph == 5) begin
        if (wb_req) begin we = 1'b1; m_wa = wb_target; m_wd = wb_data; end
`ifdef INSTR_COUNT_EN
        m_cnt = m_cnt + 16'd1;
`endif
        m_hp = 1'b0;
        if (hp) begin m_st = 3; m_ph = 0; end
        else if (m_st == 2) begin m_st = 0; m_ph = 0; end
        else m_ph = 1;
      end else begin
        m_ph = m_ph + 1;
        m_hp = hp;
      end
    end
    m_we = we;
    m_ack = ack;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.phase   = (m_ph == 0) ? 5'b0 : 5'(1 << (m_ph - 1));
    e.running = (m_st == 1) || (m_st == 2);
    e.halted  = (m_st == 3);
    e.ack     = m_ack;
    e.we      = m_we;
    e.waddr   = m_wa;
    e.wdata   = m_wd;
    e.cnt     = m_cnt;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    check("phase", 32'(phase), 32'(e.phase));
    check("running", 32'(running), 32'(e.running));
    check("halted", 32'(halted), 32'(e.halted));
    check("dbg_ack", 32'(dbg_ack), 32'(e.ack));
    check("rf_we", 32'(rf_we), 32'(e.we));
    check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
    check("rf_wdata", 32'(rf_wdata), 32'(e.wdata));
    check("instr_count", 32'(instr_count), 32'(e.cnt));
  endtask

  task automatic cyc(input logic r, input logic s, input logic h, input logic wr,
                     input logic [2:0] wt, input logic [15:0] wd,
                     input logic dr, input logic [2:0] dt, input logic [15:0] dd);
    run = r; step = s; haltin = h; wb_req = wr; wb_target = wt; wb_data = wd;
    dbg_req = dr; dbg_target = dt; dbg_data = dd;
    model_step();
    q.push_back(model_exp());
    @(posedge clock);
    #1;
    compare_out();
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
  endtask

  // asynchronous reset asserted between clock edges, checked before any edge arrives
  task automatic do_reset();
    #2;
    run = 0; step = 0; haltin = 0; wb_req = 0; dbg_req = 0;
    reset = 1'b0;
    #1;
    model_reset();
    q.push_back(model_exp());
    compare_out();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // continuous run with writebacks in p5 (taken) and p3 (ignored), halt in p2 of instruction 3
    cyc(1, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    repeat (4) nop();
    cyc(0, 0, 0, 1, 3'd5, 16'h00A5, 0, 3'd0, 16'h0);
    nop(); nop();
    cyc(0, 0, 0, 1, 3'd6, 16'h0BAD, 0, 3'd0, 16'h0);
    nop(); nop();
    nop();
    cyc(0, 0, 1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    repeat (3) nop();
    cyc(1, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    cyc(0, 1, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    repeat (4) cyc(0, 0, 0, 0, 3'd0, 16'h0, 1, 3'd7, 16'hBEEF);
    nop();
    do_reset();

    // single step, then debug writes in IDLE and a run/dbg collision
    cyc(0, 1, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    repeat (5) nop();
    nop();
    cyc(0, 0, 0, 0, 3'd0, 16'h0, 1, 3'd2, 16'h1234);
    nop();
    cyc(1, 0, 0, 0, 3'd0, 16'h0, 1, 3'd3, 16'h5678);
    repeat (7) cyc(0, 0, 0, 0, 3'd0, 16'h0, 1, 3'd3, 16'h5678);
    cyc(0, 0, 1, 0, 3'd0, 16'h0, 1, 3'd3, 16'h5678);
    repeat (8) cyc(0, 0, 0, 0, 3'd0, 16'h0, 1, 3'd3, 16'h5678);
    do_reset();

    // reset in the middle of p3
    cyc(1, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    nop(); nop();
    do_reset();

    // run and step together: run wins
    cyc(1, 1, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    repeat (7) nop();
    do_reset();

    // randomized traffic with periodic resets
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom),
          $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 16'($urandom));
      if (i % 80 == 79) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/phase_controller.md
Name: phase_controller

Overview:
- Single-clock sequencer for the five-phase SIMPLE datapath.
- Generates one-hot phase enables p1..p5 and controls run, single-step and halt.
- Arbitrates the register-file write port between pipeline writeback and a debug loader.
- Sits between the board clock and reset and the decode/register-file, ALU, memory and writeback stages.

Parameters:
- DATA_W, 16, register data width
- RADDR_W, 3, register address width (8 registers)
- CNT_W, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock; all state on its rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  one-cycle pulse: start continuous execution
- step  in  1  one-cycle pulse: execute exactly one instruction
- haltin  in  1  halt detected by decode; valid in any phase of the current instruction
- wb_req  in  1  pipeline requests a register write; sampled only in p5
- wb_target  in  RADDR_W  pipeline write address
- wb_data  in  DATA_W  pipeline write data
- dbg_req  in  1  debug loader write request; level, held until dbg_ack
- dbg_target  in  RADDR_W  debug write address
- dbg_data  in  DATA_W  debug write data
- phase  out  5  one-hot {p5,p4,p3,p2,p1}; all zero when not executing
- running  out  1  high in RUN or STEP
- halted  out  1  high in HALTED
- dbg_ack  out  1  one-cycle pulse when the debug write is performed
- rf_we  out  1  register-file write enable
- rf_waddr  out  RADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset low, async): state IDLE, phase 0, running 0, halted 0, dbg_ack 0, rf_we 0, rf_waddr 0, rf_wdata 0, instr_count 0, halt_pending 0. Reset mid-instruction aborts it; no write is issued.
- States: IDLE, RUN, STEP, HALTED. All outputs are registered.
- IDLE:
  - run -> RUN; step -> STEP. If both arrive together, run wins.
  - phase becomes 5'b00001 in the first cycle after the transition.
- RUN/STEP:
  - phase rotates p1->p2->p3->p4->p5->p1, one phase per clock.
  - haltin high in any phase sets halt_pending.
- Instruction retirement (cycle after p5):
  - instr_count increments, wrapping at 2^CNT_W-1 -> 0.
  - If halt_pending: go to HALTED, phase 0, clear halt_pending.
  - Else in STEP: go to IDLE, phase 0.
  - Else in RUN: phase returns to p1.
- run/step pulses are ignored in RUN, STEP and HALTED.
- HALTED: sticky. Only reset leaves it.
- Pipeline writeback: when phase==p5 and wb_req=1, the next cycle has rf_we=1, rf_waddr=wb_target, rf_wdata=wb_data. This write lands before the next instruction's p2.
- Debug write:
  - Served only in IDLE or HALTED.
  - If dbg_req=1 and dbg_ack=0, the next cycle has rf_we=1, rf_waddr=dbg_target, rf_wdata=dbg_data, dbg_ack=1.
  - dbg_req held through ack gives one write every two cycles.
  - If run/step is accepted in the same cycle, run/step wins; dbg_req waits with no ack until the next IDLE or HALTED.
  - dbg_req during RUN/STEP is never acked and never writes.
- rf_we is deasserted in every other cycle. rf_waddr and rf_wdata hold their last values.

Optional Feature:
- INSTR_COUNT_EN defined: instr_count behaves as described above.
- Not defined: counter logic is omitted and instr_count is constant 0.

Decomposition:
- Package simple_ctrl_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_STEP, ST_HALTED;
  - one-hot constants PH_P1..PH_P5 and PH_NONE.
- Sub-module phase_ring: 5-bit one-hot rotator with load-p1, advance and clear inputs and an at_p5 flag.

Test Plan:
- Reset low, then high; pulse run -> phase 01,02,04,08,10,01; running=1; instr_count=1 after first retirement.
- step in IDLE -> exactly five phases, then phase=0, running=0, instr_count=1.
- haltin pulsed in p2 of instruction 3 in RUN -> p3..p5 complete, then halted=1, phase=0, instr_count=3; a later run pulse has no effect.
- wb_req=1, wb_target=5, wb_data=16'h00A5 in p5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=16'h00A5; wb_req in p3 -> no write.
- In IDLE, dbg_req with dbg_target=2, dbg_data=16'h1234 -> next cycle dbg_ack=1, rf_we=1, rf_waddr=2, rf_wdata=16'h1234. dbg_req with run in the same cycle -> no ack, RUN entered.
- reset low during p3 -> immediately phase=0, state IDLE, rf_we=0, instr_count=0.
